// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl: pipeline MEM-stage requests, data-memory port,
// debug dump stream and error flag. 'slave' is the controller side, 'master' drives it.
interface mem_access_ctrl_if #(
  parameter int len_data   = 32,
  parameter int addr_width = 11
);
  logic                  pipe_rd;
  logic                  pipe_wr;
  logic                  pipe_sb;
  logic                  pipe_sh;
  logic [len_data-1:0]   pipe_addr;
  logic [len_data-1:0]   pipe_wdata;
  logic                  halt;
  logic                  pipe_stall;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [addr_width-1:0] mem_addr;
  logic [len_data-1:0]   mem_wdata;
  logic [len_data-1:0]   mem_rdata;

  // Dump stream handshake: a word transfers on a rising edge where dbg_dump_valid
  // and dbg_dump_ready are both 1; while valid is high without ready, data and
  // address stay stable; valid never depends combinationally on ready.
  logic                  dbg_dump_start;
  logic                  dbg_dump_ready;
  logic                  dbg_dump_valid;
  logic [len_data-1:0]   dbg_dump_data;
  logic [addr_width-1:0] dbg_dump_addr;
  logic                  dbg_dump_done;

  logic                  err_misalign;

  modport slave (
    input  pipe_rd, pipe_wr, pipe_sb, pipe_sh, pipe_addr, pipe_wdata, halt,
    output pipe_stall,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    input  dbg_dump_start, dbg_dump_ready,
    output dbg_dump_valid, dbg_dump_data, dbg_dump_addr, dbg_dump_done,
    output err_misalign
  );

  modport master (
    output pipe_rd, pipe_wr, pipe_sb, pipe_sh, pipe_addr, pipe_wdata, halt,
    input  pipe_stall,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    output dbg_dump_start, dbg_dump_ready,
    input  dbg_dump_valid, dbg_dump_data, dbg_dump_addr, dbg_dump_done,
    input  err_misalign
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: sub-word stores via read-modify-write, optional
// debug memory dump enabled by the macro MEM_ACCESS_CTRL_DUMP_EN.
module mem_access_ctrl #(
  parameter int len_data   = 32,
  parameter int addr_width = 11,
  parameter int dump_depth = 2048
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RMW_WRITE  = 2'd1
`ifdef MEM_ACCESS_CTRL_DUMP_EN
    ,
    DUMP_READ  = 2'd2,
    DUMP_VALID = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  rmw_done_q, rmw_done_d;
  logic [addr_width-1:0] word_addr_q, word_addr_d;
  logic [1:0]            lane_q, lane_d;
  logic                  is_byte_q, is_byte_d;
  logic [15:0]           sub_data_q, sub_data_d;
  logic                  err_q, err_d;

  logic                  sub_store;
  logic [addr_width-1:0] pipe_word;
  logic [len_data-1:0]   merged;
  logic                  dump_go;
  logic                  unused_ok;

  assign sub_store = bus.pipe_wr & (bus.pipe_sb | bus.pipe_sh);
  assign pipe_word = bus.pipe_addr[addr_width+1:2];

`ifdef MEM_ACCESS_CTRL_DUMP_EN
  localparam logic [addr_width-1:0] LAST_PTR = addr_width'(dump_depth - 1);

  logic [addr_width-1:0] dump_ptr_q, dump_ptr_d;
  logic [len_data-1:0]   dump_data_q, dump_data_d;
  logic [addr_width-1:0] dump_addr_q, dump_addr_d;
  logic                  cap_q, cap_d;
  logic                  done_q, done_d;

  assign dump_go   = (state_q == IDLE) & bus.halt & bus.dbg_dump_start;
  assign unused_ok = ^{bus.pipe_addr[len_data-1:addr_width+2]};
`else
  assign dump_go   = 1'b0;
  assign unused_ok = ^{bus.pipe_addr[len_data-1:addr_width+2], bus.halt,
                       bus.dbg_dump_start, bus.dbg_dump_ready, dump_depth[0]};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rmw_done_q  <= 1'b0;
      word_addr_q <= '0;
      lane_q      <= 2'b00;
      is_byte_q   <= 1'b0;
      sub_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef MEM_ACCESS_CTRL_DUMP_EN
      dump_ptr_q  <= '0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
      cap_q       <= 1'b0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rmw_done_q  <= rmw_done_d;
      word_addr_q <= word_addr_d;
      lane_q      <= lane_d;
      is_byte_q   <= is_byte_d;
      sub_data_q  <= sub_data_d;
      err_q       <= err_d;
`ifdef MEM_ACCESS_CTRL_DUMP_EN
      dump_ptr_q  <= dump_ptr_d;
      dump_data_q <= dump_data_d;
      dump_addr_q <= dump_addr_d;
      cap_q       <= cap_d;
      done_q      <= done_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rmw_done_d  = rmw_done_q;
    word_addr_d = word_addr_q;
    lane_d      = lane_q;
    is_byte_d   = is_byte_q;
    sub_data_d  = sub_data_q;
    err_d       = err_q;
`ifdef MEM_ACCESS_CTRL_DUMP_EN
    dump_ptr_d  = dump_ptr_q;
    dump_data_d = dump_data_q;
    dump_addr_d = dump_addr_q;
    cap_d       = 1'b0;
    done_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        rmw_done_d = 1'b0;
        if (dump_go) begin
`ifdef MEM_ACCESS_CTRL_DUMP_EN
          dump_ptr_d = '0;
          state_d    = DUMP_READ;
`endif
        end else if (sub_store && !rmw_done_q) begin
          word_addr_d = pipe_word;
          lane_d      = bus.pipe_addr[1:0];
          is_byte_d   = bus.pipe_sb;
          sub_data_d  = bus.pipe_wdata[15:0];
          // A misaligned halfword still writes the half picked by bit 1.
          if (!bus.pipe_sb && bus.pipe_addr[0]) err_d = 1'b1;
          state_d = RMW_WRITE;
        end
      end
      RMW_WRITE: begin
        rmw_done_d = 1'b1;
        state_d    = IDLE;
      end
`ifdef MEM_ACCESS_CTRL_DUMP_EN
      DUMP_READ: begin
        if (!bus.halt) begin
          state_d = IDLE;
        end else begin
          cap_d   = 1'b1;
          state_d = DUMP_VALID;
        end
      end
      DUMP_VALID: begin
        // The first cycle here only captures the word just read.
        if (cap_q) begin
          dump_data_d = bus.mem_rdata;
          dump_addr_d = dump_ptr_q;
        end
        if (!bus.halt) begin
          state_d = IDLE;
        end else if (!cap_q && bus.dbg_dump_ready) begin
          if (dump_ptr_q == LAST_PTR) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dump_ptr_d = dump_ptr_q + 1'b1;
            state_d    = DUMP_READ;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (is_byte_q) merged[{lane_q, 3'b000} +: 8]      = sub_data_q[7:0];
    else           merged[{lane_q[1], 4'b0000} +: 16] = sub_data_q;
  end

  // Output logic; everything combinational is forced low while in reset.
  always_comb begin
    bus.pipe_stall = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          bus.mem_addr  = pipe_word;
          bus.mem_wdata = bus.pipe_wdata;
          if (dump_go) begin
            bus.pipe_stall = 1'b1;
          end else if (sub_store) begin
            if (!rmw_done_q) begin
              bus.mem_rd     = 1'b1;
              bus.pipe_stall = 1'b1;
            end
          end else begin
            bus.mem_rd = bus.pipe_rd;
            bus.mem_wr = bus.pipe_wr & ~bus.pipe_rd;
          end
        end
        RMW_WRITE: begin
          bus.mem_wr     = 1'b1;
          bus.pipe_stall = 1'b1;
          bus.mem_addr   = word_addr_q;
          bus.mem_wdata  = merged;
        end
`ifdef MEM_ACCESS_CTRL_DUMP_EN
        DUMP_READ: begin
          bus.mem_rd     = 1'b1;
          bus.mem_addr   = dump_ptr_q;
          bus.pipe_stall = 1'b1;
        end
        DUMP_VALID: begin
          bus.pipe_stall = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_DUMP_EN
  assign bus.dbg_dump_valid = reset & (state_q == DUMP_VALID) & ~cap_q;
  assign bus.dbg_dump_data  = dump_data_q;
  assign bus.dbg_dump_addr  = dump_addr_q;
  assign bus.dbg_dump_done  = done_q;
`else
  assign bus.dbg_dump_valid = 1'b0;
  assign bus.dbg_dump_data  = '0;
  assign bus.dbg_dump_addr  = '0;
  assign bus.dbg_dump_done  = 1'b0;
`endif

  assign bus.err_misalign = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural data memory; dump cases
// run only when MEM_ACCESS_CTRL_DUMP_EN is defined.
module tb_mem_access_ctrl;
  localparam int LD = 32;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  logic [LD-1:0] mem [0:(1<<AW)-1];

  mem_access_ctrl_if #(.len_data(LD), .addr_width(AW)) bus ();

  mem_access_ctrl #(.len_data(LD), .addr_width(AW), .dump_depth(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.dbg_dump_done) done_cnt <= done_cnt + 1;
    if (bus.mem_rd && bus.mem_wr) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [LD-1:0] got, input logic [LD-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_rd = 1'b0; bus.pipe_wr = 1'b0; bus.pipe_sb = 1'b0; bus.pipe_sh = 1'b0;
    bus.pipe_addr = '0; bus.pipe_wdata = '0;
  endtask

  logic          rmw_rd_seen, rmw_wr_seen;
  logic [LD-1:0] rmw_wdata, rmw_first_rdata;

  // Holds a sub-word store until the stall drops; leaves it driven in that cycle.
  task automatic run_store(input logic sb, input logic sh, input logic [LD-1:0] addr,
                           input logic [LD-1:0] data, output int stalls);
    @(negedge clk);
    idle();
    bus.pipe_wr = 1'b1; bus.pipe_sb = sb; bus.pipe_sh = sh;
    bus.pipe_addr = addr; bus.pipe_wdata = data;
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!bus.pipe_stall) break;
      if (k == 0) begin
        rmw_rd_seen = bus.mem_rd;
        rmw_first_rdata = bus.mem_rdata;
      end
      if (k == 1) begin
        rmw_wr_seen = bus.mem_wr;
        rmw_wdata = bus.mem_wdata;
      end
      stalls++;
      @(negedge clk);
    end
  endtask

`ifdef MEM_ACCESS_CTRL_DUMP_EN
  logic [LD-1:0] dump_exp [0:3];

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      if (bus.dbg_dump_valid) break;
      @(negedge clk); #1;
    end
    check(tag, bus.dbg_dump_valid, 1'b1);
  endtask

  task automatic accept();
    bus.dbg_dump_ready = 1'b1;
    @(negedge clk);
    bus.dbg_dump_ready = 1'b0;
  endtask
`endif

  initial begin
    int st;
    idle();
    bus.halt = 1'b0; bus.dbg_dump_start = 1'b0; bus.dbg_dump_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset: outputs low even with a request driven
    bus.pipe_rd = 1'b1;
    #2;
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_stall", bus.pipe_stall, 1'b0);
    check("rst_err", bus.err_misalign, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_valid", bus.dbg_dump_valid, 1'b0);
    check("rst_done", bus.dbg_dump_done, 1'b0);
    @(negedge clk); reset = 1'b1; idle();

    // Word store passes through unstalled
    @(negedge clk);
    bus.pipe_wr = 1'b1; bus.pipe_addr = 32'h100; bus.pipe_wdata = 32'hCAFEF00D;
    #1;
    check("sw_wr", bus.mem_wr, 1'b1);
    check("sw_stall", bus.pipe_stall, 1'b0);
    check("sw_addr", bus.mem_addr, 32'h40);
    @(negedge clk); idle();
    check("sw_mem", mem[11'h40], 32'hCAFEF00D);

    // SB to 0x41 on AABBCCDD
    mem[11'h10] = 32'hAABBCCDD;
    run_store(1'b1, 1'b0, 32'h41, 32'h11, st);
    check("sb_stalls", st, 2);
    check("sb_rd", rmw_rd_seen, 1'b1);
    check("sb_wr", rmw_wr_seen, 1'b1);
    check("sb_wdata", rmw_wdata, 32'hAABB11DD);
    check("sb_third_wr", bus.mem_wr, 1'b0);
    check("sb_third_rd", bus.mem_rd, 1'b0);
    check("sb_mem", mem[11'h10], 32'hAABB11DD);

    // SH to 0x42
    @(negedge clk); idle();
    mem[11'h10] = 32'hAABBCCDD;
    run_store(1'b0, 1'b1, 32'h42, 32'h1234, st);
    check("sh_stalls", st, 2);
    check("sh_mem", mem[11'h10], 32'h1234CCDD);
    check("sh_no_err", bus.err_misalign, 1'b0);

    // LW, SB, LW back-to-back
    mem[11'h20] = 32'h01020304;
    @(negedge clk); idle();
    bus.pipe_rd = 1'b1; bus.pipe_addr = 32'h80;
    #1;
    check("lw1_stall", bus.pipe_stall, 1'b0);
    check("lw1_rd", bus.mem_rd, 1'b1);
    run_store(1'b1, 1'b0, 32'h83, 32'hEE, st);
    check("lw1_data", rmw_first_rdata, 32'h01020304);
    check("b2b_sb_stalls", st, 2);
    @(negedge clk); idle();
    bus.pipe_rd = 1'b1; bus.pipe_addr = 32'h80;
    #1;
    check("lw2_stall", bus.pipe_stall, 1'b0);
    @(negedge clk); idle();
    #1;
    check("lw2_data", bus.mem_rdata, 32'hEE020304);

    // Misaligned SH to 0x43: upper half written, sticky error
    mem[11'h10] = 32'hAABBCCDD;
    run_store(1'b0, 1'b1, 32'h43, 32'hBEEF, st);
    check("shm_mem", mem[11'h10], 32'hBEEFCCDD);
    check("shm_err", bus.err_misalign, 1'b1);
    @(negedge clk); idle();
    bus.pipe_wr = 1'b1; bus.pipe_addr = 32'h104; bus.pipe_wdata = 32'h5;
    @(negedge clk); idle();
    @(negedge clk);
    check("shm_err_sticky", bus.err_misalign, 1'b1);

    // Reset during RMW_WRITE: no write happens
    mem[11'h30] = 32'h55667788;
    @(negedge clk);
    bus.pipe_wr = 1'b1; bus.pipe_sb = 1'b1; bus.pipe_addr = 32'hC0; bus.pipe_wdata = 32'h99;
    @(negedge clk); #1;
    check("rr_state", dbg_state, 2'd1);
    st = wr_cnt;
    #1 reset = 1'b0;
    #1;
    check("rr_wr_low", bus.mem_wr, 1'b0);
    check("rr_err_clr", bus.err_misalign, 1'b0);
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk);
    check("rr_mem", mem[11'h30], 32'h55667788);
    check("rr_wr_cnt", wr_cnt, st);
    check("rr_state_idle", dbg_state, 2'd0);

`ifdef MEM_ACCESS_CTRL_DUMP_EN
    dump_exp[0] = 32'h11111111; dump_exp[1] = 32'h22222222;
    dump_exp[2] = 32'h33333333; dump_exp[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem[i] = dump_exp[i];
    @(negedge clk);
    bus.halt = 1'b1; bus.dbg_dump_start = 1'b1;
    @(negedge clk); bus.dbg_dump_start = 1'b0; #1;
    check("dump_stall", bus.pipe_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("dump_valid_%0d", i));
      check($sformatf("dump_addr_%0d", i), bus.dbg_dump_addr, LD'(i));
      check($sformatf("dump_data_%0d", i), bus.dbg_dump_data, dump_exp[i]);
      if (i == 1) begin
        for (int w = 0; w < 3; w++) begin
          @(negedge clk); #1;
          check("dump_hold_valid", bus.dbg_dump_valid, 1'b1);
          check("dump_hold_addr", bus.dbg_dump_addr, 32'd1);
          check("dump_hold_data", bus.dbg_dump_data, dump_exp[1]);
        end
      end
      accept();
    end
    repeat (3) @(negedge clk);
    check("dump_done_cnt", done_cnt, 1);
    check("dump_end_state", dbg_state, 2'd0);

    // Abandon on word 2 by dropping halt
    bus.dbg_dump_start = 1'b1;
    @(negedge clk); bus.dbg_dump_start = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      wait_valid("abort_valid");
      accept();
    end
    wait_valid("abort_valid2");
    check("abort_addr", bus.dbg_dump_addr, 32'd2);
    bus.halt = 1'b0;
    @(negedge clk); #1;
    check("abort_state", dbg_state, 2'd0);
    check("abort_valid_low", bus.dbg_dump_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 1);
`else
    @(negedge clk);
    bus.halt = 1'b1; bus.dbg_dump_start = 1'b1; bus.dbg_dump_ready = 1'b1;
    #1;
    check("nodump_stall", bus.pipe_stall, 1'b0);
    @(negedge clk); bus.dbg_dump_start = 1'b0; #1;
    check("nodump_state", dbg_state, 2'd0);
    check("nodump_valid", bus.dbg_dump_valid, 1'b0);
    check("nodump_rd", bus.mem_rd, 1'b0);
    check("nodump_data", bus.dbg_dump_data, 32'd0);
    check("nodump_done", done_cnt, 0);
    bus.halt = 1'b0; bus.dbg_dump_ready = 1'b0;
`endif

    check("rd_wr_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter len_data, default 32: data word width.
REQ-002 Parameter addr_width, default 11: data-memory word-address width.
REQ-003 Parameter dump_depth, default 2048: number of words swept by a debug dump.
REQ-004 Reset is asynchronous and active-low; the block has a single clock domain.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pipe_rd, pipe_wr  in  1 each  MEM-stage load and store requests.
REQ-008 pipe_sb, pipe_sh  in  1 each  sub-word store qualifiers: byte and halfword.
REQ-009 pipe_addr  in  len_data  MEM-stage byte address.
REQ-010 pipe_wdata  in  len_data  store data; the sub-word is in the low bits.
REQ-011 halt  in  1  pipeline halted; debug dump is permitted only while halt=1.
REQ-012 pipe_stall  out  1  freezes the pipeline up to and including MEM.
REQ-013 mem_rd, mem_wr  out  1 each  data-memory strobes.
REQ-014 mem_addr  out  addr_width  memory word address.
REQ-015 mem_wdata  out  len_data  memory write data.
REQ-016 mem_rdata  in  len_data  memory read data, valid one cycle after mem_rd.
REQ-017 dbg_dump_start  in  1  one-cycle request to start a dump.
REQ-018 dbg_dump_ready  in  1  dump consumer ready.
REQ-019 dbg_dump_valid  out  1  dump word valid.
REQ-020 dbg_dump_data  out  len_data  dump word.
REQ-021 dbg_dump_addr  out  addr_width  word address of dbg_dump_data.
REQ-022 dbg_dump_done  out  1  one-cycle pulse after the last word is accepted.
REQ-023 err_misalign  out  1  sticky flag: a halfword store was issued with pipe_addr[0]=1.

Function
REQ-024 Word address mapping SHALL be mem_addr = pipe_addr[addr_width+1:2]; byte lanes are little-endian.
REQ-025 Byte lanes SHALL be selected by pipe_addr[1:0] for byte stores and by pipe_addr[1] for halfword stores.
REQ-026 States: IDLE, RMW_WRITE, DUMP_READ, DUMP_VALID.
REQ-027 IDLE, loads and word stores: mem_rd=pipe_rd and mem_wr=pipe_wr&~pipe_sb&~pipe_sh, combinationally, with pipe_stall=0.
REQ-028 IDLE, sub-word store with rmw_done=0:
  - mem_rd=1 and pipe_stall=1;
  - latch word address, lane, size and data;
  - next state RMW_WRITE.
REQ-029 RMW_WRITE:
  - mem_wr=1 and pipe_stall=1;
  - mem_wdata = mem_rdata with only the selected lane(s) replaced;
  - set rmw_done; next state IDLE.
REQ-030 IDLE with rmw_done=1: the held sub-word store is ignored (no strobe, pipe_stall=0) and rmw_done clears, so each sub-word store costs exactly 3 cycles, 2 of them stalled.
REQ-031 Halfword store with pipe_addr[0]=1: the write is performed using pipe_addr[1] only, and err_misalign is set until reset.
REQ-032 IDLE with halt=1 and dbg_dump_start=1: clear dump_ptr to 0 and go to DUMP_READ; dbg_dump_start is ignored in every other state.
REQ-033 DUMP_READ: mem_rd=1 with mem_addr=dump_ptr; next state DUMP_VALID.
REQ-034 DUMP_VALID, first cycle: capture mem_rdata into dbg_dump_data.
REQ-035 DUMP_VALID: hold dbg_dump_valid=1 with stable data and address until dbg_dump_ready=1.
REQ-036 DUMP_VALID, on handshake:
  - if dump_ptr == dump_depth-1: pulse dbg_dump_done and go to IDLE;
  - otherwise increment dump_ptr and go to DUMP_READ.
REQ-037 If halt falls during DUMP_READ or DUMP_VALID, the dump SHALL be abandoned: go to IDLE with no done pulse and dbg_dump_valid=0 on the next cycle.
REQ-038 In dump states, pipe_* inputs SHALL be ignored and pipe_stall=1.
REQ-039 mem_rd and mem_wr SHALL never be asserted in the same cycle.

Reset
REQ-040 While reset=0, all outputs and state SHALL clear:
  - state=IDLE;
  - rmw_done, dump_ptr, err_misalign, dbg_dump_data and dbg_dump_addr = 0;
  - all strobes, pipe_stall, dbg_dump_valid and dbg_dump_done = 0.
REQ-041 Reset asserted mid read-modify-write or mid-dump SHALL abort the operation with no memory write.

Configuration
REQ-042 Macro MEM_ACCESS_CTRL_DUMP_EN defined: the debug dump is implemented as specified.
REQ-043 Macro MEM_ACCESS_CTRL_DUMP_EN undefined:
  - DUMP_READ and DUMP_VALID are absent;
  - dbg_dump_start and dbg_dump_ready are ignored;
  - dbg_dump_valid, dbg_dump_data, dbg_dump_addr and dbg_dump_done are tied to 0.

Verification
REQ-044 Memory word 0x10 = 0xAABBCCDD; SB to byte address 0x41 with data 0x11 -> mem_wdata=0xAABB11DD, pipe_stall high for exactly 2 cycles.
REQ-045 Memory word 0x10 = 0xAABBCCDD; SH to byte address 0x42 with data 0x1234 -> word 0x10 = 0x1234CCDD.
REQ-046 LW, then SB, then LW back-to-back -> the loads are not stalled, the SB stalls 2 cycles, and the final load returns the merged word.
REQ-047 halt=1, dump_depth=4, dbg_dump_ready held low for 3 cycles on word 1 -> data and address stable while waiting; addresses 0,1,2,3 delivered; done pulses once.
REQ-048 halt dropped during DUMP_VALID of word 2 -> IDLE next cycle, no done pulse; reset pulsed during RMW_WRITE -> target word unchanged.
REQ-049 SH to byte address 0x43 -> err_misalign=1 and remains set until reset.
